// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package serial_adder_pkg;

   // Operand/result width used when the parent does not override it.
   localparam int DEFAULT_WIDTH = 8;

   // Control FSM encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// Existing one-bit full adder shared across the codebase.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: processes one operand bit pair per clock, LSB first, through
// a single full_adder with a registered carry loop-back. Result and carry are
// updated only on the edge that finishes the last bit and then held.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din_start,
   input  logic [WIDTH-1:0] din_A,
   input  logic [WIDTH-1:0] din_B,
   input  logic             din_cin,
   output logic             dout_busy,
   output logic             dout_done,
   output logic [WIDTH-1:0] dout_sum,
   output logic             dout_carry
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] sh_a_r;
   logic [WIDTH-1:0] sh_b_r;
   logic [WIDTH-1:0] psum_r;
   logic [CW-1:0]    cnt_r;
   logic             carry_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             fa_sum_s;
   logic             fa_cout_s;
   logic             last_bit_s;

   // One full adder, fed from the shift-register LSBs and the looped-back carry.
   full_adder u_fa (
      .a    (sh_a_r[0]),
      .b    (sh_b_r[0]),
      .cin  (carry_r),
      .sum  (fa_sum_s),
      .cout (fa_cout_s)
   );

   assign last_bit_s = (cnt_r == LAST_CNT);

   // Next-state logic: a start is only honoured in IDLE; DONE always lasts one cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (din_start) begin
               state_nxt_s = ST_ADD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ADD: begin
            if (last_bit_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_ADD;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register plus status flags registered from the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == ST_ADD);
         done_r  <= (state_nxt_s == ST_DONE);
      end
   end

   // Operand capture, bit-serial shifting, carry loop-back and result load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_a_r  <= '0;
         sh_b_r  <= '0;
         psum_r  <= '0;
         cnt_r   <= '0;
         carry_r <= 1'b0;
         sum_r   <= '0;
         cout_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (din_start) begin
                  sh_a_r  <= din_A;
                  sh_b_r  <= din_B;
                  carry_r <= din_cin;
                  psum_r  <= '0;
                  cnt_r   <= '0;
               end
            end
            ST_ADD: begin
               sh_a_r  <= {1'b0, sh_a_r[WIDTH-1:1]};
               sh_b_r  <= {1'b0, sh_b_r[WIDTH-1:1]};
               psum_r  <= {fa_sum_s, psum_r[WIDTH-1:1]};
               carry_r <= fa_cout_s;
               if (last_bit_s) begin
                  // Counter parks at its last value instead of wrapping.
                  sum_r  <= {fa_sum_s, psum_r[WIDTH-1:1]};
                  cout_r <= fa_cout_s;
               end else begin
                  cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               sh_a_r <= sh_a_r;
            end
         endcase
      end
   end

   assign dout_busy  = busy_r;
   assign dout_done  = done_r;
   assign dout_sum   = sum_r;
   assign dout_carry = cout_r;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (WIDTH=8).
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         din_start;
   logic [W-1:0] din_A;
   logic [W-1:0] din_B;
   logic         din_cin;
   logic         dout_busy;
   logic         dout_done;
   logic [W-1:0] dout_sum;
   logic         dout_carry;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] exp_sum;
      logic       exp_carry;
   } vec_t;

   vec_t vecs [9];

   serial_adder #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din_start  (din_start),
      .din_A      (din_A),
      .din_B      (din_B),
      .din_cin    (din_cin),
      .dout_busy  (dout_busy),
      .dout_done  (dout_done),
      .dout_sum   (dout_sum),
      .dout_carry (dout_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one operation from IDLE, scramble operands after acceptance, check timing and result.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] es, input logic ec);
      int done_at;
      int busy_cnt;
      done_at  = 0;
      busy_cnt = 0;
      din_A = a; din_B = b; din_cin = cin; din_start = 1'b1;
      step();
      din_start = 1'b0;
      din_A = ~a; din_B = ~b; din_cin = ~cin;
      for (int n = 1; n <= 20; n++) begin
         if (dout_done) begin
            done_at = n;
            break;
         end
         if (dout_busy) busy_cnt++;
         step();
      end
      check({tag, " done_cycle"}, done_at, 9);
      check({tag, " busy_cycles"}, busy_cnt, 8);
      check({tag, " busy_in_done"}, {31'd0, dout_busy}, 32'd0);
      check({tag, " sum"}, {24'd0, dout_sum}, {24'd0, es});
      check({tag, " carry"}, {31'd0, dout_carry}, {31'd0, ec});
      step();
      check({tag, " done_pulse_width"}, {31'd0, dout_done}, 32'd0);
   endtask

   initial begin
      int  done_cnt;
      int  last_done;
      bit  held_ok;
      bit  sum_ok;
      bit  gap_ok;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[3] = '{8'h10, 8'h20, 1'b1, 8'h31, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
      vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

      rst_n = 1'b0; din_start = 1'b0; din_A = '0; din_B = '0; din_cin = 1'b0;
      step(); step();
      check("reset busy",  {31'd0, dout_busy},  32'd0);
      check("reset done",  {31'd0, dout_done},  32'd0);
      check("reset sum",   {24'd0, dout_sum},   32'd0);
      check("reset carry", {31'd0, dout_carry}, 32'd0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 9; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].exp_sum, vecs[i].exp_carry);
      end

      // Result of FF+FF+1 must hold through 20 idle cycles.
      held_ok = 1'b1;
      for (int n = 0; n < 20; n++) begin
         if (dout_sum !== 8'hFF || dout_carry !== 1'b1 || dout_done !== 1'b0) held_ok = 1'b0;
         step();
      end
      check("idle hold", {31'd0, held_ok}, 32'd1);

      // Start pulse during ADD is ignored; previous result held while busy.
      din_A = 8'h12; din_B = 8'h34; din_cin = 1'b0; din_start = 1'b1;
      step();
      din_start = 1'b0;
      step();
      check("busy hold sum", {24'd0, dout_sum}, 32'h0000_00FF);
      step();
      din_A = 8'hFF; din_B = 8'hFF; din_cin = 1'b1; din_start = 1'b1;
      step();
      din_start = 1'b0;
      done_cnt = 0;
      for (int n = 0; n < 25; n++) begin
         if (dout_done) begin
            done_cnt++;
            check("ignored start sum",   {24'd0, dout_sum},   32'h0000_0046);
            check("ignored start carry", {31'd0, dout_carry}, 32'd0);
         end
         step();
      end
      check("ignored start done count", done_cnt, 1);

      // Reset at busy cycle 4 aborts and clears the held result.
      din_A = 8'h80; din_B = 8'h80; din_cin = 1'b0; din_start = 1'b1;
      step();
      din_start = 1'b0;
      step(); step(); step();
      check("pre-abort busy", {31'd0, dout_busy}, 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort busy",  {31'd0, dout_busy},  32'd0);
      check("abort done",  {31'd0, dout_done},  32'd0);
      check("abort sum",   {24'd0, dout_sum},   32'd0);
      check("abort carry", {31'd0, dout_carry}, 32'd0);
      done_cnt = 0;
      for (int n = 0; n < 12; n++) begin
         if (dout_done) done_cnt++;
         step();
      end
      check("abort no done", done_cnt, 0);
      run_op("after abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

      // Start held high: a result every 10 cycles.
      din_A = 8'h10; din_B = 8'h20; din_cin = 1'b1; din_start = 1'b1;
      done_cnt  = 0;
      last_done = -1;
      sum_ok    = 1'b1;
      gap_ok    = 1'b1;
      for (int n = 1; n <= 45; n++) begin
         step();
         if (dout_done) begin
            done_cnt++;
            if (dout_sum !== 8'h31 || dout_carry !== 1'b0) sum_ok = 1'b0;
            if (last_done < 0) begin
               if (n != 9) gap_ok = 1'b0;
            end else begin
               if (n - last_done != 10) gap_ok = 1'b0;
            end
            last_done = n;
         end
      end
      din_start = 1'b0;
      check("continuous done count", done_cnt, 4);
      check("continuous spacing", {31'd0, gap_ok}, 32'd1);
      check("continuous result", {31'd0, sum_ok}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_serial_adder
